// File: rtl/layer1_mac_engine_if.sv
// ---------------------------------------------------------------------------
// layer1_mac_engine_if
// PIO-facing bus of the layer-1 MAC engine.
//   cmd_word     : 32-bit command word driven by the HPS PIO out_port
//   status_word  : 32-bit status/result word read by the HPS PIO in_port
//   result_pulse : one-cycle strobe when FINISH writes a new result
// Modports:
//   master : HPS/PIO side (drives cmd_word)
//   slave  : engine side (drives status_word, result_pulse)
// ---------------------------------------------------------------------------
interface layer1_mac_engine_if;
   logic [31:0] cmd_word;
   logic [31:0] status_word;
   logic        result_pulse;

   modport master (output cmd_word, input status_word, input result_pulse);
   modport slave  (input cmd_word, output status_word, output result_pulse);
endinterface

// File: rtl/layer1_mac_engine.sv
// ---------------------------------------------------------------------------
// layer1_mac_engine
// Fixed-point single-neuron MAC engine for MLP layer 1. The HPS issues
// CLEAR / LOAD_X / MAC_W / LOAD_BIAS / FINISH commands through a toggle-bit
// handshake and reads back a saturated, optionally ReLU-clamped result.
// Ports:
//   clk      : system clock (PIO domain)
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport
//              cmd_word    [31] seq, [30:28] opcode, [27:16] reserved,
//                          [15:0] signed operand
//              status_word [31] ack, [30] busy, [29] sat, [28] err,
//                          [27:16] term count, [15:0] result
//              result_pulse  one-cycle strobe on FINISH completion
// ---------------------------------------------------------------------------
module layer1_mac_engine #(
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40,
   parameter int RELU_EN   = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   layer1_mac_engine_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, EXEC, MUL, ACC, FIN1, FIN2} state_t;

   localparam logic signed [ACC_W:0] R_MAX =
      {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] R_MIN = ~R_MAX;

   state_t                      state;
   logic [31:0]                 cmd_q;
   logic [2:0]                  op_l;
   logic signed [DATA_W-1:0]    opnd_l;
   logic                        ack;
   logic                        sat;
   logic                        err;
   logic [11:0]                 count;
   logic [DATA_W-1:0]           result;
   logic signed [DATA_W-1:0]    x;
   logic signed [DATA_W-1:0]    bias;
   logic signed [ACC_W-1:0]     acc;
   logic signed [2*DATA_W-1:0]  prod;
   logic signed [ACC_W:0]       fin;
   logic                        result_pulse;

   // FINISH datapath; one extra bit keeps the bias add from wrapping.
   logic signed [ACC_W:0]       fin_sum;
   logic signed [ACC_W:0]       fin_r;
   logic                        sat_now;
   logic [DATA_W-1:0]           res_next;
   logic                        unused_rsvd;

   assign fin_sum = (ACC_W+1)'(acc) + ((ACC_W+1)'(bias) <<< FRAC_BITS);
   assign unused_rsvd = ^cmd_q[27:16];

   always_comb begin
      fin_r    = fin;
      sat_now  = 1'b0;
      res_next = fin[DATA_W-1:0];
      if ((RELU_EN != 0) && (fin < 0)) begin
         fin_r = '0;
      end
      res_next = fin_r[DATA_W-1:0];
      if (fin_r > R_MAX) begin
         sat_now  = 1'b1;
         res_next = R_MAX[DATA_W-1:0];
      end else if (fin_r < R_MIN) begin
         sat_now  = 1'b1;
         res_next = R_MIN[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cmd_q        <= '0;
         op_l         <= '0;
         opnd_l       <= '0;
         ack          <= 1'b0;
         sat          <= 1'b0;
         err          <= 1'b0;
         count        <= '0;
         result       <= '0;
         x            <= '0;
         bias         <= '0;
         acc          <= '0;
         prod         <= '0;
         fin          <= '0;
         result_pulse <= 1'b0;
      end else begin
         cmd_q        <= bus.cmd_word;
         result_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_q[31] != ack) begin
                  op_l   <= cmd_q[30:28];
                  opnd_l <= cmd_q[DATA_W-1:0];
                  case (cmd_q[30:28])
                     3'd3:    state <= MUL;
                     3'd5:    state <= FIN1;
                     default: state <= EXEC;
                  endcase
               end
            end
            EXEC: begin
               case (op_l)
                  3'd1: begin
                     acc   <= '0;
                     count <= '0;
                     sat   <= 1'b0;
                     err   <= 1'b0;
                  end
                  3'd2:       x    <= opnd_l;
                  3'd4:       bias <= opnd_l;
                  3'd6, 3'd7: err  <= 1'b1;
                  default: ;
               endcase
               // ack follows the live seq bit: a seq toggled back while busy
               // leaves seq==ack, so the lost write is never re-executed.
               ack   <= cmd_q[31];
               state <= IDLE;
            end
            MUL: begin
               prod  <= (2*DATA_W)'(x) * (2*DATA_W)'(opnd_l);
               state <= ACC;
            end
            ACC: begin
               acc   <= acc + ACC_W'(prod);
               count <= (count == 12'hFFF) ? count : count + 12'd1;
               ack   <= cmd_q[31];
               state <= IDLE;
            end
            FIN1: begin
               fin   <= fin_sum >>> FRAC_BITS;
               state <= FIN2;
            end
            FIN2: begin
               result       <= res_next;
               if (sat_now) sat <= 1'b1;
               result_pulse <= 1'b1;
               ack          <= cmd_q[31];
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.status_word  = {ack, (state != IDLE), sat, err, count, 16'(result)};
   assign bus.result_pulse = result_pulse;

endmodule
